// File: rtl/serial_adder_param_if.sv
// Operand/result bundle for the digit-serial adder/subtractor.
interface serial_adder_param_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sub;
    logic             cin;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (output start, sub, cin, a, b, input busy, done, sum, cout, ovf);
    modport slave  (input start, sub, cin, a, b, output busy, done, sum, cout, ovf);
endinterface

// File: rtl/serial_adder_param.sv
// Digit-serial adder/subtractor: one DIGIT-bit slice with a registered carry,
// WIDTH/DIGIT cycles per operation, sum/cout/ovf published with a done pulse.
module serial_adder_param #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input logic                clk,
    input logic                rst,
    serial_adder_param_if.slave bus
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_sh_q, a_sh_d, b_sh_q, b_sh_d;
    logic [WIDTH-1:0]   res_q, res_d, sum_q, sum_d;
    logic               carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [DIGIT:0]     slice;
    logic               c_msb;
    logic [WIDTH+DIGIT-1:0] res_cat;

    always_comb begin
        slice   = {1'b0, a_sh_q[DIGIT-1:0]} + {1'b0, b_sh_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_q};
        // Carry into the digit's top bit, recovered from its sum and operand bits
        c_msb   = slice[DIGIT-1] ^ a_sh_q[DIGIT-1] ^ b_sh_q[DIGIT-1];
        res_cat = {slice[DIGIT-1:0], res_q} >> DIGIT;
    end

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    a_sh_d  = bus.a;
                    b_sh_d  = bus.sub ? ~bus.b : bus.b;
                    carry_d = bus.sub | bus.cin;
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                res_d   = res_cat[WIDTH-1:0];
                a_sh_d  = a_sh_q >> DIGIT;
                b_sh_d  = b_sh_q >> DIGIT;
                carry_d = slice[DIGIT];
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    state_d = DONE;
                    sum_d   = res_cat[WIDTH-1:0];
                    cout_d  = slice[DIGIT];
                    ovf_d   = c_msb ^ slice[DIGIT];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.busy = (state_q == RUN);
    assign bus.done = (state_q == DONE);
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_serial_adder_param.sv
// Bench for serial_adder_param: five configurations against an arithmetic reference.
module tb_serial_adder_param;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] a_drv, b_drv;
    logic       sub_drv, cin_drv;
    logic [4:0] st;
    int         n_checks = 0;
    int         n_fail   = 0;

    always #5 clk = ~clk;

    // 0: W8/D1  1: W8/D4  2: W8/D2  3: W4/D1  4: W4/D4
    serial_adder_param_if #(.WIDTH(8)) if0 ();
    serial_adder_param_if #(.WIDTH(8)) if1 ();
    serial_adder_param_if #(.WIDTH(8)) if2 ();
    serial_adder_param_if #(.WIDTH(4)) if3 ();
    serial_adder_param_if #(.WIDTH(4)) if4 ();

    serial_adder_param #(.WIDTH(8), .DIGIT(1)) u0 (.clk(clk), .rst(rst), .bus(if0));
    serial_adder_param #(.WIDTH(8), .DIGIT(4)) u1 (.clk(clk), .rst(rst), .bus(if1));
    serial_adder_param #(.WIDTH(8), .DIGIT(2)) u2 (.clk(clk), .rst(rst), .bus(if2));
    serial_adder_param #(.WIDTH(4), .DIGIT(1)) u3 (.clk(clk), .rst(rst), .bus(if3));
    serial_adder_param #(.WIDTH(4), .DIGIT(4)) u4 (.clk(clk), .rst(rst), .bus(if4));

    assign if0.start = st[0]; assign if0.a = a_drv;      assign if0.b = b_drv;
    assign if1.start = st[1]; assign if1.a = a_drv;      assign if1.b = b_drv;
    assign if2.start = st[2]; assign if2.a = a_drv;      assign if2.b = b_drv;
    assign if3.start = st[3]; assign if3.a = a_drv[3:0]; assign if3.b = b_drv[3:0];
    assign if4.start = st[4]; assign if4.a = a_drv[3:0]; assign if4.b = b_drv[3:0];
    assign if0.sub = sub_drv; assign if1.sub = sub_drv; assign if2.sub = sub_drv;
    assign if3.sub = sub_drv; assign if4.sub = sub_drv;
    assign if0.cin = cin_drv; assign if1.cin = cin_drv; assign if2.cin = cin_drv;
    assign if3.cin = cin_drv; assign if4.cin = cin_drv;

    logic [4:0] busy_v, done_v, cout_v, ovf_v;
    logic [7:0] sum_v [5];
    logic [7:0] prev_sum [5];

    assign busy_v = {if4.busy, if3.busy, if2.busy, if1.busy, if0.busy};
    assign done_v = {if4.done, if3.done, if2.done, if1.done, if0.done};
    assign cout_v = {if4.cout, if3.cout, if2.cout, if1.cout, if0.cout};
    assign ovf_v  = {if4.ovf,  if3.ovf,  if2.ovf,  if1.ovf,  if0.ovf};
    assign sum_v[0] = if0.sum;
    assign sum_v[1] = if1.sum;
    assign sum_v[2] = if2.sum;
    assign sum_v[3] = {4'b0, if3.sum};
    assign sum_v[4] = {4'b0, if4.sum};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: {ovf, cout, sum} from integer arithmetic on the operand values
    function automatic logic [9:0] model(input int w, input int a, input int b,
                                         input bit s, input bit c);
        int mask, half, bb, tot, sa, sb, sr;
        bit ov;
        mask = (1 << w) - 1;
        half = 1 << (w - 1);
        bb   = s ? (~b & mask) : b;
        tot  = a + bb + (s ? 1 : int'(c));
        sa   = (a >= half) ? a - (1 << w) : a;
        sb   = (b >= half) ? b - (1 << w) : b;
        sr   = s ? sa - sb : sa + sb + int'(c);
        ov   = (sr > half - 1) || (sr < -half);
        return {ov, 1'((tot >> w) & 1), 8'(tot & mask)};
    endfunction

    task automatic start_op(input int idx, input logic [7:0] a, input logic [7:0] b,
                            input logic s, input logic c);
        a_drv = a; b_drv = b; sub_drv = s; cin_drv = c;
        st[idx] = 1'b1;
        @(posedge clk); #1;
        st[idx] = 1'b0;
        a_drv = 8'($urandom); b_drv = 8'($urandom);
        sub_drv = 1'($urandom); cin_drv = 1'($urandom);
    endtask

    task automatic finish_op(input int idx, input int n, input logic [9:0] exp,
                             input int poke, input string tag);
        int cyc = 0;
        int iter = 0;
        while (done_v[idx] !== 1'b1 && iter < n + 3) begin
            if (busy_v[idx] === 1'b1) begin
                cyc++;
                check({tag, " held"}, sum_v[idx], prev_sum[idx]);
            end
            if (poke >= 0 && cyc == poke) begin
                st[idx] = 1'b1; a_drv = 8'hFF; b_drv = 8'hFF;
            end else begin
                st[idx] = 1'b0;
            end
            iter++;
            @(posedge clk); #1;
        end
        st[idx] = 1'b0;
        check({tag, " done"},  done_v[idx], 1);
        check({tag, " lat"},   iter, n);
        check({tag, " nbusy"}, cyc, n);
        check({tag, " busy0"}, busy_v[idx], 0);
        check({tag, " sum"},   sum_v[idx], exp[7:0]);
        check({tag, " cout"},  cout_v[idx], exp[8]);
        check({tag, " ovf"},   ovf_v[idx], exp[9]);
        prev_sum[idx] = exp[7:0];
    endtask

    task automatic run_op(input int idx, input int w, input int n, input logic [7:0] a,
                          input logic [7:0] b, input logic s, input logic c,
                          input int poke, input string tag);
        logic [9:0] exp;
        exp = model(w, int'(a), int'(b), s, c);
        start_op(idx, a, b, s, c);
        finish_op(idx, n, exp, poke, tag);
    endtask

    task automatic outs_zero(input int idx, input string tag);
        check({tag, " busy"}, busy_v[idx], 0);
        check({tag, " done"}, done_v[idx], 0);
        check({tag, " sum"},  sum_v[idx], 0);
        check({tag, " cout"}, cout_v[idx], 0);
        check({tag, " ovf"},  ovf_v[idx], 0);
    endtask

    initial begin
        rst = 1'b1; st = '0;
        a_drv = '0; b_drv = '0; sub_drv = 1'b0; cin_drv = 1'b0;
        for (int i = 0; i < 5; i++) prev_sum[i] = '0;
        repeat (2) @(posedge clk);
        #1;
        outs_zero(0, "rst0");
        outs_zero(3, "rst3");
        rst = 1'b0;
        @(posedge clk); #1;
        outs_zero(1, "idle1");

        // Plain add with signed overflow
        run_op(0, 8, 8, 8'h5A, 8'h3C, 1'b0, 1'b0, -1, "t1");
        check("t1 lit sum", sum_v[0], 8'h96);
        check("t1 lit ovf", ovf_v[0], 1);
        @(posedge clk); #1;
        check("t1 pulse", done_v[0], 0);
        check("t1 keep",  sum_v[0], 8'h96);

        // Back-to-back: second start issued in the DONE cycle
        run_op(0, 8, 8, 8'hFF, 8'h01, 1'b0, 1'b0, -1, "t2a");
        check("t2a lit cout", cout_v[0], 1);
        run_op(0, 8, 8, 8'h10, 8'h20, 1'b1, 1'b0, -1, "t2b");
        check("t2b lit sum", sum_v[0], 8'hF0);

        // DIGIT=4 subtract, two busy cycles
        run_op(1, 8, 2, 8'h80, 8'h01, 1'b1, 1'b0, -1, "t3");
        check("t3 lit sum", sum_v[1], 8'h7F);
        check("t3 lit ovf", ovf_v[1], 1);

        // DIGIT=2 add with a stray start during RUN
        run_op(2, 8, 4, 8'h12, 8'h34, 1'b0, 1'b0, 1, "t4");
        check("t4 lit sum", sum_v[2], 8'h46);
        @(posedge clk); #1;
        check("t4 no restart", busy_v[2], 0);

        // Reset during the 4th RUN cycle
        @(posedge clk); #1;
        start_op(0, 8'hC3, 8'h5D, 1'b0, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check("t5 busy before", busy_v[0], 1);
        rst = 1'b1;
        #1;
        outs_zero(0, "t5 async");
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) prev_sum[i] = '0;
        for (int i = 0; i < 10; i++) begin
            check("t5 no done", done_v[0], 0);
            @(posedge clk); #1;
        end
        run_op(0, 8, 8, 8'hC3, 8'h5D, 1'b0, 1'b1, -1, "t5 after");

        // Random operations on the 8-bit configurations
        for (int k = 0; k < 40; k++) begin
            run_op(0, 8, 8, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), -1, "r0");
            run_op(1, 8, 2, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), -1, "r1");
            run_op(2, 8, 4, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
                   int'($urandom_range(0, 3)) - 1, "r2");
            if ($urandom_range(0, 1) == 1) begin
                @(posedge clk); #1;
            end
        end

        // Exhaustive 4-bit sweeps, back-to-back
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                for (int m = 0; m < 4; m++) begin
                    run_op(3, 4, 4, 8'(a), 8'(b), m[1], m[0], -1, "ex3");
                    run_op(4, 4, 1, 8'(a), 8'(b), m[1], m[0], -1, "ex4");
                end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/serial_adder_param.md
Name: serial_adder_param

Overview:
- Parametrised digit-serial adder/subtractor; the sequential successor to the team's single-bit combinational full adder.
- Accepts two WIDTH-bit operands on a start pulse and processes DIGIT bits per clock through one DIGIT-bit adder slice with a registered carry.
- Returns the sum, carry-out and signed overflow with a done pulse.
- Used where area matters more than latency: ALU slow paths and bit-serial datapaths.

Parameters:
- WIDTH, 8, operand and result width in bits; must be ≥ 1 and an integer multiple of DIGIT.
- DIGIT, 1, bits processed per clock; 1 ≤ DIGIT ≤ WIDTH.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request a new operation; sampled on the rising edge.
- sub  in  1  0 = a+b+cin; 1 = a−b (cin ignored); sampled with start.
- a  in  WIDTH  operand A; sampled with start.
- b  in  WIDTH  operand B; sampled with start.
- cin  in  1  carry-in for add mode; sampled with start.
- busy  out  1  high while digits are being processed.
- done  out  1  one-cycle pulse when sum/cout/ovf update.
- sum  out  WIDTH  result; holds its value until the next completion.
- cout  out  1  final carry-out; in sub mode, 1 means no borrow.
- ovf  out  1  two's-complement overflow, equal to carry into MSB XOR carry out of MSB.

Behaviour:
- Reset, asynchronous and immediate:
  - Outputs: busy=0, done=0, sum=0, cout=0, ovf=0.
  - FSM goes to IDLE; digit counter, carry and operand shift registers are cleared.
  - Reset mid-operation aborts the operation, and its partial result is never presented.
- FSM states: IDLE, RUN, DONE. Define N = WIDTH/DIGIT.
- IDLE or DONE, with start=1 at an edge (the accept edge):
  - Latch a into the A shift register.
  - Latch b into the B shift register, using ~b when sub=1.
  - Initialise carry to 1 if sub=1, else cin.
  - Clear the counter and go to RUN; busy=1 from that edge.
- IDLE or DONE, with start=0: go to (or stay in) IDLE.
- RUN, each edge:
  - Add the low DIGIT bits of A, B and carry.
  - Shift the DIGIT-bit result into the top of the internal result register (LSB digit first).
  - Shift A and B right by DIGIT, update carry, and increment the counter.
- RUN, on the edge that processes digit N−1:
  - Go to DONE.
  - Copy the full result register to sum, final carry to cout, and the overflow term to ovf.
  - Capture the carry into the MSB from inside the final digit slice.
  - Set busy=0 and done=1.
- Latency: done is high in the cycle after the N-th edge following the accept edge; busy is high for exactly N cycles.
- DONE lasts one cycle only; done=0 on the next edge unless a new start is accepted there.
  - A new start in DONE is accepted with no bubble, giving back-to-back throughput of one result per N+1 cycles.
- start while busy=1 is ignored; inputs are not re-sampled and the operation completes unaffected.
- a, b, sub and cin may change freely after the accept edge.
- sum, cout and ovf change only on the completion edge or on reset; they are stable while busy.
- Arithmetic: result is modulo 2^WIDTH.
  - Add mode: {cout,sum} = a + b + cin.
  - Sub mode: {cout,sum} = a + ~b + 1.
- WIDTH=DIGIT (N=1): a single RUN cycle; done is high in the cycle after the edge following accept.

Test Plan:
- WIDTH=8, DIGIT=1, add a=0x5A b=0x3C cin=0 -> after 8 busy cycles: done pulse, sum=0x96, cout=0, ovf=1.
- WIDTH=8, DIGIT=1, add a=0xFF b=0x01 cin=0, then a start in the DONE cycle with sub a=0x10 b=0x20:
  - first result: sum=0x00, cout=1, ovf=0.
  - second result: sum=0xF0, cout=0, ovf=0, with no idle cycle between operations.
- WIDTH=8, DIGIT=4, sub a=0x80 b=0x01 -> busy exactly 2 cycles, sum=0x7F, cout=1, ovf=1.
- WIDTH=8, DIGIT=2, add a=0x12 b=0x34, with start pulsed again with a=0xFF during RUN -> second start ignored; sum=0x46, cout=0, ovf=0.
- Assert rst for one cycle during the 4th RUN cycle of an operation -> all outputs 0 immediately, no done pulse; the next operation after reset completes correctly.
- WIDTH=4, DIGIT=1 and DIGIT=4: exhaustive sweep of a, b, cin, sub (1024 ops) -> sum/cout/ovf match the reference model on every done pulse.
